bus_control_sequencer: RTL
==========================

// Module: bus_control_sequencer
// PURPOSE
// - Clocked, parametrised successor to the PIC bus control logic: synchronises CS_bar/RD_bar/WR_bar and
//   captures write data. Runs the ICW1->ICW2->[ICW3]->[ICW4] initialisation sequence as an FSM.
// - Emits one-cycle ICW/OCW write strobes with registered data, and drives the read data path.
// - Sits between the external CPU bus and the PIC's register/priority logic.
// PARAMETERS
// - DATA_WIDTH   8  bus width; min 8; bits [4:0] decoded, upper bits passed through in write_data
// - SYNC_STAGES  2  flops per CS_bar/RD_bar/WR_bar synchroniser; min 1
// PORTS
// - clk            in   1   single clock; all state on rising edge
// - reset          in   1   asynchronous, active-high
// - CS_bar,RD_bar,WR_bar in 1 async active-low bus controls
// - A0             in   1   address bit
// - data_bus_in    in   DW  CPU write data
// - read_data_in   in   DW  internal register data for CPU reads (IRR/ISR/IMR mux, selected elsewhere)
// - data_bus_out   out  DW  read data; 0 when data_bus_oe=0
// - data_bus_oe    out  1   pad output enable (= read)
// - write_data     out  DW  captured write data; valid with any strobe, held until next write
// - icw_1..icw_4, ocw_1..ocw_3  out 1 each  one-cycle write strobes; at most one high per cycle
// - ic4, sngl      out  1   ICW1 bits D0, D1, latched on icw_1
// - init_done      out  1   high in READY
// - read           out  1   synchronised ~RD & ~CS & no write active (level)
// BEHAVIOUR
// - Reset: all outputs 0, write_data=0, FSM=UNINIT, synchroniser flops hold deasserted (1).
// - wr_act = ~cs_s & ~wr_s, where _s are the synchronised signals. Each cycle wr_act=1, write_data<=data_bus_in
//   and a0_q<=A0. Bus must hold data/A0 until SYNC_STAGES+1 clk after WR_bar rises.
// - Write commits on the 1->0 edge of wr_act (WR or CS rising, whichever first); strobe asserted the
//   cycle after the edge is detected, i.e. SYNC_STAGES+1 clk after raw release. One strobe per pulse.
// - Decode at commit using write_data (d) and a0_q:
//   ICW1 = a0=0 & d[4]; OCW2 = a0=0 & ~d[4] & ~d[3]; OCW3 = a0=0 & ~d[4] & d[3]; A1 = a0=1.
// - FSM states UNINIT, WAIT2, WAIT3, WAIT4, READY.
// - ICW1 in ANY state -> icw_1, latch ic4=d[0], sngl=d[1], go WAIT2 (re-init aborts a sequence).
// - WAIT2: A1 -> icw_2; next WAIT3 if sngl=0, else WAIT4 if ic4=1, else READY.
// - WAIT3: A1 -> icw_3; next WAIT4 if ic4=1 else READY.
// - WAIT4: A1 -> icw_4; next READY.
// - READY: A1->ocw_1, OCW2->ocw_2, OCW3->ocw_3; state unchanged.
// - UNINIT or WAITn with a0=0 & ~d[4], or UNINIT with a0=1: no strobe, state unchanged.
// - init_done=1 only in READY; drops the cycle icw_1 pulses.
// - Read: read = ~cs_s & ~rd_s & ~wr_act; data_bus_out = read ? read_data_in : 0 (combinational from regs).
//   RD+WR low together: write wins, read=0.
// - reset mid-sequence or mid-pulse: immediate return to reset values; a pending write is discarded.
// CONFIGURATION
// - Macro BUS_CTRL_ACCESS_ERR_EN adds ports err_pulse (out 1) and err_sticky (out 1).
// - err_pulse fires for one cycle on each write the FSM ignores; err_sticky sets with it and is
//   cleared only by reset or icw_1.
// - Without the macro: ports absent, ignored writes silently dropped, all else identical.
// TESTING
// - Reset, then ICW1 d=0x13 (sngl=1, ic4=1), then A1 0x08 and A1 0x01. Required: icw_1, icw_2,
//   icw_4 in order, icw_3 never, init_done=1 after icw_4.
// - ICW1 0x10, then three A1 writes 0x20/0x04/0xFF. Required: icw_2, icw_3, then ocw_1 with
//   write_data=0xFF; init_done rises after icw_3.
// - READY, a0=0 writes 0x20 then 0x0B. Required: ocw_2 then ocw_3; each strobe exactly 1 clk,
//   SYNC_STAGES+1 clk after WR_bar rises.
// - READY, ICW1 0x12 mid-operation, then A1 0x40. Required: init_done=0 and icw_1; then icw_2 and
//   READY (sngl=1, ic4=0).
// - read_data_in=0xA5, CS_bar=0, RD_bar=0 for 6 clk. Required: read=1 and data_bus_out=0xA5 after
//   SYNC_STAGES clk; WR_bar low during the read forces read=0.
// - With macro: A1 write 0x55 after reset. Required: no strobe, err_pulse for 1 clk, err_sticky=1
//   until icw_1. Assert reset during WAIT3: all outputs 0 asynchronously.

Source files
------------

// File: rtl/bus_control_sequencer_if.sv
// CPU-side bus of the PIC bus control sequencer: raw strobes, address, write data and read-back pads.
interface bus_control_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  CS_bar;
  logic                  RD_bar;
  logic                  WR_bar;
  logic                  A0;
  logic [DATA_WIDTH-1:0] data_bus_in;
  logic [DATA_WIDTH-1:0] data_bus_out;
  logic                  data_bus_oe;

  modport master (
    output CS_bar, RD_bar, WR_bar, A0, data_bus_in,
    input  data_bus_out, data_bus_oe
  );

  modport slave (
    input  CS_bar, RD_bar, WR_bar, A0, data_bus_in,
    output data_bus_out, data_bus_oe
  );
endinterface

// File: rtl/bus_control_sequencer.sv
// PIC bus control: synchronises CPU strobes, runs ICW1..ICW4 init FSM, emits one-cycle ICW/OCW strobes.
// Optional macro BUS_CTRL_ACCESS_ERR_EN adds err_pulse/err_sticky reporting of ignored writes.
module bus_control_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  bus_control_sequencer_if.slave bus,
  input  logic [DATA_WIDTH-1:0] read_data_in,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  icw_1,
  output logic                  icw_2,
  output logic                  icw_3,
  output logic                  icw_4,
  output logic                  ocw_1,
  output logic                  ocw_2,
  output logic                  ocw_3,
  output logic                  ic4,
  output logic                  sngl,
  output logic                  init_done,
  output logic                  read
`ifdef BUS_CTRL_ACCESS_ERR_EN
 ,output logic                  err_pulse,
  output logic                  err_sticky
`endif
);

  typedef enum logic [2:0] {UNINIT, WAIT2, WAIT3, WAIT4, READY} state_t;

  state_t     state_q, state_d;
  logic [2:0] sync_p [SYNC_STAGES];
  logic       cs_s, rd_s, wr_s;
  logic       wr_act, wr_act_p1, commit;
  logic       a0_q;
  logic [6:0] strb_q, strb_d;
  logic       ic4_d, sngl_d;
  logic       is_icw1, is_ocw2, is_a1;

  // Stage 0: strobe synchronisers, idle (deasserted) out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= 3'b111;
    end else begin
      sync_p[0] <= {bus.CS_bar, bus.RD_bar, bus.WR_bar};
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
    end
  end

  assign {cs_s, rd_s, wr_s} = sync_p[SYNC_STAGES-1];
  assign wr_act = ~cs_s & ~wr_s;
  assign commit = wr_act_p1 & ~wr_act;

  // Stage 1: capture data/address while the write is active, remember activity for edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_act_p1  <= 1'b0;
      write_data <= '0;
      a0_q       <= 1'b0;
    end else begin
      wr_act_p1 <= wr_act;
      if (wr_act) begin
        write_data <= bus.data_bus_in;
        a0_q       <= bus.A0;
      end
    end
  end

  assign is_icw1 = ~a0_q & write_data[4];
  assign is_ocw2 = ~a0_q & ~write_data[4] & ~write_data[3];
  assign is_a1   = a0_q;

  // Strobe vector order: {icw_1, icw_2, icw_3, icw_4, ocw_1, ocw_2, ocw_3}
  always_comb begin
    state_d = state_q;
    strb_d  = '0;
    ic4_d   = ic4;
    sngl_d  = sngl;
    if (commit) begin
      if (is_icw1) begin
        strb_d[6] = 1'b1;
        ic4_d     = write_data[0];
        sngl_d    = write_data[1];
        state_d   = WAIT2;
      end else begin
        unique case (state_q)
          WAIT2: if (is_a1) begin
            strb_d[5] = 1'b1;
            state_d   = !sngl ? WAIT3 : (ic4 ? WAIT4 : READY);
          end
          WAIT3: if (is_a1) begin
            strb_d[4] = 1'b1;
            state_d   = ic4 ? WAIT4 : READY;
          end
          WAIT4: if (is_a1) begin
            strb_d[3] = 1'b1;
            state_d   = READY;
          end
          READY: begin
            if (is_a1)        strb_d[2] = 1'b1;
            else if (is_ocw2) strb_d[1] = 1'b1;
            else              strb_d[0] = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Stage 2: FSM state, registered strobes and latched ICW1 mode bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= UNINIT;
      strb_q  <= '0;
      ic4     <= 1'b0;
      sngl    <= 1'b0;
    end else begin
      state_q <= state_d;
      strb_q  <= strb_d;
      ic4     <= ic4_d;
      sngl    <= sngl_d;
    end
  end

  assign {icw_1, icw_2, icw_3, icw_4, ocw_1, ocw_2, ocw_3} = strb_q;
  assign init_done = (state_q == READY);

  // A simultaneous write masks the read so the pads never fight the CPU
  assign read             = ~cs_s & ~rd_s & ~wr_act;
  assign bus.data_bus_oe  = read;
  assign bus.data_bus_out = read ? read_data_in : '0;

`ifdef BUS_CTRL_ACCESS_ERR_EN
  logic ignored;
  assign ignored = commit & ~(|strb_d);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      err_pulse <= ignored;
      if (strb_d[6])    err_sticky <= 1'b0;
      else if (ignored) err_sticky <= 1'b1;
    end
  end
`endif

endmodule
